snake_dir_ctrl: RTL and testbench



---
 rtl/snake_pkg.sv | 18 +
 rtl/btn_debounce.sv | 30 +++
 rtl/snake_dir_ctrl.sv | 104 ++++++++++
 tb/tb_snake_dir_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared direction encoding and helpers for the snake direction scheduler.
package snake_pkg;

  typedef enum logic [1:0] {
    UP    = 2'b00,
    DOWN  = 2'b01,
    LEFT  = 2'b10,
    RIGHT = 2'b11
  } dir_t;

  localparam dir_t DIR_RESET = RIGHT;

  // UP/DOWN and LEFT/RIGHT differ only in bit 0.
  function automatic dir_t opposite(input dir_t d);
    return dir_t'(d ^ 2'b01);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Single-line debouncer: the stable level follows raw only after raw has
// differed from it for DEBOUNCE_CYCLES consecutive cycles.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic stable
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      stable <= 1'b0;
      cnt    <= '0;
    end else if (raw == stable) begin
      cnt <= '0;
    end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
      stable <= raw;
      cnt    <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/snake_dir_ctrl.sv
// Direction scheduler: debounced button presses become legal direction
// requests, queued and released one per game tick.
module snake_dir_ctrl
  import snake_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int QUEUE_DEPTH     = 2
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [3:0]                         btn,
  input  logic                               tick,
  output logic [1:0]                         dir,
  output logic                               dir_changed,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0]   q_count,
  output logic                               drop
);

  localparam int QCW = $clog2(QUEUE_DEPTH + 1);
  localparam int PW  = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;

  logic [3:0]     stable;
  logic [3:0]     stable_q;
  logic [3:0]     press;
  logic [1:0]     mem [QUEUE_DEPTH];
  logic [PW-1:0]  rd_ptr;
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  tail_ptr;
  logic [QCW-1:0] cnt_post;
  logic [1:0]     head;
  logic [1:0]     tail;
  logic [1:0]     ref_dir;
  logic [1:0]     code;
  logic           pop;
  logic           push;
  logic           multi;
  logic           illegal;
  logic           full;
  logic           drop_next;

  for (genvar i = 0; i < 4; i++) begin : g_db
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk    (clk),
      .reset  (reset),
      .raw    (btn[i]),
      .stable (stable[i])
    );
  end

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(QUEUE_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign press    = stable & ~stable_q;
  assign pop      = tick && (q_count != '0);
  assign cnt_post = q_count - QCW'(pop);
  assign tail_ptr = (wr_ptr == '0) ? PW'(QUEUE_DEPTH - 1) : wr_ptr - PW'(1);
  assign head     = mem[rd_ptr];
  assign tail     = mem[tail_ptr];

  // Legality is judged against where the snake will be heading once every
  // already-accepted request (after this cycle's pop) has been applied.
  assign ref_dir  = (cnt_post != '0) ? tail : (pop ? head : dir);

  always_comb begin
    code = 2'b00;
    for (int i = 3; i >= 0; i--) begin
      if (press[i]) code = 2'(i);
    end
  end

  assign multi     = (press & (press - 4'd1)) != 4'd0;
  assign illegal   = (code == ref_dir) || (code == opposite(dir_t'(ref_dir)));
  assign full      = (cnt_post == QCW'(QUEUE_DEPTH));
  assign push      = (press != 4'd0) && !illegal && !full;
  assign drop_next = multi || ((press != 4'd0) && (illegal || full));

  always_ff @(posedge clk) begin
    if (reset) begin
      dir         <= DIR_RESET;
      dir_changed <= 1'b0;
      drop        <= 1'b0;
      q_count     <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      stable_q    <= '0;
      for (int i = 0; i < QUEUE_DEPTH; i++) mem[i] <= DIR_RESET;
    end else begin
      stable_q    <= stable;
      dir_changed <= pop;
      drop        <= drop_next;
      q_count     <= cnt_post + QCW'(push);
      if (pop) begin
        dir    <= head;
        rd_ptr <= next_ptr(rd_ptr);
      end
      if (push) begin
        mem[wr_ptr] <= code;
        wr_ptr      <= next_ptr(wr_ptr);
      end
    end
  end

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// Bench for snake_dir_ctrl: directed scenarios then random button/tick
// traffic, all checked every cycle against a queue-based reference model.
module tb_snake_dir_ctrl;

  localparam int DB    = 4;
  localparam int DEPTH = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] btn;
  logic       tick;
  logic [1:0] dir;
  logic       dir_changed;
  logic [1:0] q_count;
  logic       drop;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  snake_dir_ctrl #(.DEBOUNCE_CYCLES(DB), .QUEUE_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .btn         (btn),
    .tick        (tick),
    .dir         (dir),
    .dir_changed (dir_changed),
    .q_count     (q_count),
    .drop        (drop)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [1:0] m_q[$];
  logic [3:0] hist[$];
  logic [3:0] m_stable, m_stable_q;
  logic [1:0] m_dir;
  logic       m_dchg, m_drop;

  task automatic model_step(input logic [3:0] b, input logic t, input logic r);
    logic [3:0] pr;
    logic [1:0] rd, cd;
    logic       found, differ;
    if (r) begin
      m_q.delete(); hist.delete();
      m_dir = 2'b11; m_dchg = 1'b0; m_drop = 1'b0;
      m_stable = 4'd0; m_stable_q = 4'd0;
      return;
    end
    pr = m_stable & ~m_stable_q;
    m_dchg = t && (m_q.size() > 0);
    if (m_dchg) m_dir = m_q.pop_front();
    rd = (m_q.size() > 0) ? m_q[m_q.size()-1] : m_dir;
    m_drop = 1'b0;
    found = 1'b0;
    cd = 2'b00;
    for (int i = 0; i < 4; i++) begin
      if (pr[i]) begin
        if (!found) begin found = 1'b1; cd = 2'(i); end
        else m_drop = 1'b1;
      end
    end
    if (found) begin
      if (cd == rd || cd == (rd ^ 2'b01) || m_q.size() >= DEPTH) m_drop = 1'b1;
      else m_q.push_back(cd);
    end
    m_stable_q = m_stable;
    // A level is accepted once the last DB raw samples all disagree with it.
    hist.push_back(b);
    if (hist.size() > DB) void'(hist.pop_front());
    if (hist.size() == DB) begin
      for (int i = 0; i < 4; i++) begin
        differ = 1'b1;
        for (int k = 0; k < DB; k++) if (hist[k][i] == m_stable[i]) differ = 1'b0;
        if (differ) m_stable[i] = ~m_stable[i];
      end
    end
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic step(input logic [3:0] b, input logic t, input logic r);
    btn = b; tick = t; reset = r;
    model_step(b, t, r);
    @(posedge clk); #1;
    cyc++;
    check("dir", {2'b00, dir}, {2'b00, m_dir});
    check("dir_changed", {3'b000, dir_changed}, {3'b000, m_dchg});
    check("q_count", {2'b00, q_count}, 4'(m_q.size()));
    check("drop", {3'b000, drop}, {3'b000, m_drop});
  endtask

  task automatic hold(input logic [3:0] b, input logic t, input int n);
    for (int i = 0; i < n; i++) step(b, t, 1'b0);
  endtask

  task automatic press_release(input logic [3:0] b);
    hold(b, 1'b0, 6);
    hold(4'd0, 1'b0, 2);
  endtask

  initial begin
    logic [3:0] rb;
    int         len;
    btn = 4'd0; tick = 1'b0; reset = 1'b1;
    @(posedge clk); #1;

    // Reset and idle
    step(4'd0, 1'b0, 1'b1);
    step(4'd0, 1'b0, 1'b1);
    hold(4'd0, 1'b0, 10);
    check("idle_dir", {2'b00, dir}, 4'h3);
    check("idle_qc", {2'b00, q_count}, 4'h0);

    // Short glitch is ignored
    hold(4'b0001, 1'b0, 3);
    hold(4'd0, 1'b0, 1);
    hold(4'd0, 1'b1, 1);
    hold(4'd0, 1'b0, 3);
    check("glitch_dir", {2'b00, dir}, 4'h3);

    // Valid UP press then tick
    hold(4'b0001, 1'b0, 6);
    check("up_queued", {2'b00, q_count}, 4'h1);
    hold(4'd0, 1'b1, 1);
    check("up_commit", {2'b00, dir}, 4'h0);
    check("up_pulse", {3'b000, dir_changed}, 4'h1);
    hold(4'd0, 1'b0, 6);

    // Reverse and repeat are dropped
    step(4'd0, 1'b0, 1'b1);
    press_release(4'b0100);
    press_release(4'b1000);
    hold(4'd0, 1'b0, 4);
    check("rev_dir", {2'b00, dir}, 4'h3);

    // Queue fills, overflow dropped, drained by ticks
    press_release(4'b0001);
    press_release(4'b0100);
    press_release(4'b0010);
    hold(4'd0, 1'b0, 4);
    check("full_qc", {2'b00, q_count}, 4'h2);
    hold(4'd0, 1'b1, 1);
    check("drain1", {2'b00, dir}, 4'h0);
    hold(4'd0, 1'b1, 1);
    check("drain2", {2'b00, dir}, 4'h2);
    hold(4'd0, 1'b1, 1);
    check("drain3_dir", {2'b00, dir}, 4'h2);
    check("drain3_pulse", {3'b000, dir_changed}, 4'h0);

    // Press edge coincides with tick on a full queue
    step(4'd0, 1'b0, 1'b1);
    press_release(4'b0001);
    press_release(4'b0100);
    hold(4'b0010, 1'b0, 4);
    hold(4'b0010, 1'b1, 1);
    check("same_edge_dir", {2'b00, dir}, 4'h0);
    check("same_edge_qc", {2'b00, q_count}, 4'h2);
    check("same_edge_drop", {3'b000, drop}, 4'h0);
    hold(4'd0, 1'b0, 2);

    // Reset in the middle of a debounce
    hold(4'b1000, 1'b0, 2);
    step(4'd0, 1'b0, 1'b1);
    hold(4'd0, 1'b0, 8);
    check("mid_reset_qc", {2'b00, q_count}, 4'h0);
    check("mid_reset_dir", {2'b00, dir}, 4'h3);

    // Random traffic
    for (int s = 0; s < 150; s++) begin
      case ($urandom_range(0, 4))
        0:       rb = 4'd0;
        1:       rb = 4'($urandom_range(0, 15));
        default: rb = 4'(1 << $urandom_range(0, 3));
      endcase
      len = $urandom_range(1, 9);
      for (int c = 0; c < len; c++)
        step(rb, ($urandom_range(0, 5) == 0), ($urandom_range(0, 299) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
